// File: rtl/gpio_mulpop_pkg.sv
// Shared types and constants for the GPIO multiply/popcount core.
// Imported by the top-level FSM and the shift-add multiplier.
package gpio_mulpop_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        POP  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_POP = 1'b1;

endpackage

// File: rtl/gpio_mulpop_mul_shift_add.sv
// Sequential shift-add multiplier: one partial product per step, fixed WIDTH steps.
// A pass-through load places zero-extended a in the accumulator for popcount-only use.
module mul_shift_add
    import gpio_mulpop_pkg::*;
#(
    parameter int WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 pass,
    input  logic                 step,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 last,
    output logic [2*WIDTH-1:0]   product
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [2*WIDTH-1:0] a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [2*WIDTH-1:0] acc;
    logic [IW-1:0]      cnt;
    logic               busy_r;

    // a is kept pre-shifted so each step adds a << i without a barrel shifter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_sh   <= '0;
            b_sh   <= '0;
            acc    <= '0;
            cnt    <= '0;
            busy_r <= 1'b0;
        end else if (load) begin
            a_sh   <= {{WIDTH{1'b0}}, a};
            b_sh   <= b;
            acc    <= pass ? {{WIDTH{1'b0}}, a} : '0;
            cnt    <= '0;
            busy_r <= ~pass;
        end else if (step && busy_r) begin
            if (b_sh[0]) begin
                acc <= acc + a_sh;
            end
            a_sh <= a_sh << 1;
            b_sh <= b_sh >> 1;
            cnt  <= cnt + IW'(1);
            if (last) begin
                busy_r <= 1'b0;
            end
        end
    end

    assign busy    = busy_r;
    assign last    = busy_r && (cnt == IW'(WIDTH - 1));
    assign product = acc;

endmodule

// File: rtl/gpio_mulpop.sv
// GPIO-facing multiply/popcount core: FSM, bit-serial popcount, result registers
// and a wrapping completed-operation counter around the shift-add multiplier.
module gpio_mulpop
    import gpio_mulpop_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int OUT_W = 32,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       mode,
    input  logic [WIDTH-1:0]           a,
    input  logic [WIDTH-1:0]           b,
    output logic [OUT_W-1:0]           w,
    output logic [$clog2(OUT_W+1)-1:0] l,
    output logic                       ready,
    output logic                       done,
    output logic                       valid,
    output logic [1:0]                 status,
    output logic [CNT_W-1:0]           gpio
);

    localparam int L_W   = $clog2(OUT_W + 1);
    localparam int IDX_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    state_t state, next_state;

    logic                 accept;
    logic                 mul_load, mul_pass, mul_step, mul_busy, mul_last;
    logic [2*WIDTH-1:0]   product;
    logic [OUT_W-1:0]     window;
    logic                 upper_zero;
    logic                 pop_bit, pop_last;
    logic [IDX_W-1:0]     pop_idx;
    logic [L_W-1:0]       pop_cnt;

    logic [OUT_W-1:0]     w_r;
    logic [L_W-1:0]       l_r;
    logic                 valid_r, done_r;
    logic [CNT_W-1:0]     gpio_r;

    mul_shift_add #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .load    (mul_load),
        .pass    (mul_pass),
        .step    (mul_step),
        .a       (a),
        .b       (b),
        .busy    (mul_busy),
        .last    (mul_last),
        .product (product)
    );

    assign window  = product[OUT_W-1:0];
    assign pop_bit = window[pop_idx];
    assign pop_last = (pop_idx == IDX_W'(OUT_W - 1));

    // With a full-width window nothing can be truncated away
    generate
        if (OUT_W == 2*WIDTH) begin : g_full
            assign upper_zero = 1'b1;
        end else begin : g_trunc
            assign upper_zero = ~|product[2*WIDTH-1:OUT_W];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start) next_state = (mode == MODE_POP) ? POP : MULT;
            MULT: if (mul_last) next_state = POP;
            POP:  if (pop_last) next_state = DONE;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        ready    = (state == IDLE);
        mul_step = (state == MULT) && mul_busy;
    end

    assign accept   = ready && start;
    assign mul_load = accept;
    assign mul_pass = (mode == MODE_POP);

    // Results, status and counter all commit on the last popcount step, so they
    // are visible together with done during the DONE cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pop_idx <= '0;
            pop_cnt <= '0;
            w_r     <= '0;
            l_r     <= '0;
            valid_r <= 1'b1;
            done_r  <= 1'b0;
            gpio_r  <= '0;
        end else begin
            done_r <= 1'b0;
            if (accept) begin
                pop_idx <= '0;
                pop_cnt <= '0;
            end else if (state == POP) begin
                pop_idx <= pop_idx + IDX_W'(1);
                pop_cnt <= pop_cnt + L_W'(pop_bit);
                if (pop_last) begin
                    w_r     <= window;
                    l_r     <= pop_cnt + L_W'(pop_bit);
                    valid_r <= upper_zero;
                    done_r  <= 1'b1;
                    gpio_r  <= gpio_r + CNT_W'(1);
                end
            end
        end
    end

    assign w      = w_r;
    assign l      = l_r;
    assign valid  = valid_r;
    assign done   = done_r;
    assign gpio   = gpio_r;
    assign status = {ready, valid_r};

endmodule

// File: tb/tb_gpio_mulpop.sv
// Scoreboard bench for gpio_mulpop: stimulus pushes expected results, monitors
// pop and compare on every done pulse, including done-cycle timing.
module tb_gpio_mulpop;

    localparam int WIDTH = 24;
    localparam int OUT_W = 32;
    localparam int CNT_W = 16;
    localparam int L_W   = 6;

    logic             clk;
    logic             reset;
    logic             start, mode;
    logic [WIDTH-1:0] a, b;
    logic [OUT_W-1:0] w;
    logic [L_W-1:0]   l;
    logic             ready, done, valid;
    logic [1:0]       status;
    logic [CNT_W-1:0] gpio;

    logic             start4, mode4;
    logic [WIDTH-1:0] a4, b4;
    logic [OUT_W-1:0] w4;
    logic [L_W-1:0]   l4;
    logic             ready4, done4, valid4;
    logic [1:0]       status4;
    logic [3:0]       gpio4;

    gpio_mulpop #(.WIDTH(WIDTH), .OUT_W(OUT_W), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .a(a), .b(b),
        .w(w), .l(l), .ready(ready), .done(done), .valid(valid),
        .status(status), .gpio(gpio)
    );

    gpio_mulpop #(.WIDTH(WIDTH), .OUT_W(OUT_W), .CNT_W(4)) u_dut4 (
        .clk(clk), .reset(reset), .start(start4), .mode(mode4), .a(a4), .b(b4),
        .w(w4), .l(l4), .ready(ready4), .done(done4), .valid(valid4),
        .status(status4), .gpio(gpio4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [OUT_W-1:0] w;
        logic [L_W-1:0]   l;
        logic             valid;
        logic [CNT_W-1:0] gpio;
        int               due;
    } exp_t;

    typedef struct {
        logic [3:0] gpio;
        int         due;
    } exp4_t;

    exp_t  sb[$];
    exp4_t sb4[$];
    logic [CNT_W-1:0] gpio_model = '0;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor for the default-parameter instance
    always @(negedge clk) begin
        exp_t e;
        if (!reset && done) begin
            if (sb.size() == 0) begin
                check_output("spurious_done", 64'(done), 64'(0));
            end else begin
                e = sb.pop_front();
                check_output("w",       64'(w),      64'(e.w));
                check_output("l",       64'(l),      64'(e.l));
                check_output("valid",   64'(valid),  64'(e.valid));
                check_output("gpio",    64'(gpio),   64'(e.gpio));
                check_output("status",  64'(status), 64'({1'b0, e.valid}));
                check_output("done_at", 64'(cyc),    64'(e.due));
            end
        end
    end

    // Monitor for the 4-bit-counter instance
    always @(negedge clk) begin
        exp4_t e;
        if (!reset && done4) begin
            if (sb4.size() == 0) begin
                check_output("spurious_done4", 64'(done4), 64'(0));
            end else begin
                e = sb4.pop_front();
                check_output("gpio4",    64'(gpio4),   64'(e.gpio));
                check_output("w4",       64'(w4),      64'(32'h0000_0003));
                check_output("l4",       64'(l4),      64'(2));
                check_output("status4",  64'(status4), 64'(2'b01));
                check_output("valid4",   64'(valid4),  64'(1));
                check_output("done4_at", 64'(cyc),     64'(e.due));
            end
        end
    end

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && (sb.size() != 0 || sb4.size() != 0); i++) @(negedge clk);
        if (sb.size() != 0 || sb4.size() != 0)
            check_output("drain_timeout", 64'(sb.size() + sb4.size()), 64'(0));
        @(negedge clk);
    endtask

    task automatic apply_stimulus(input logic m, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                  input logic [OUT_W-1:0] ew, input logic [L_W-1:0] el, input logic ev);
        exp_t e;
        @(negedge clk);
        mode  = m;
        a     = av;
        b     = bv;
        start = 1'b1;
        gpio_model = gpio_model + 1'b1;
        e.w = ew; e.l = el; e.valid = ev; e.gpio = gpio_model;
        e.due = cyc + (m ? 33 : 57);
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        wait_drain(200);
        check_output("idle_status", 64'(status), 64'({1'b1, ev}));
    endtask

    initial begin
        exp_t e;
        exp4_t e4;
        int k;
        reset = 1'b1;
        start = 1'b0; mode = 1'b0; a = '0; b = '0;
        start4 = 1'b0; mode4 = 1'b1; a4 = 24'h000003; b4 = 24'h0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check_output("rst_w",      64'(w),      64'(0));
        check_output("rst_l",      64'(l),      64'(0));
        check_output("rst_gpio",   64'(gpio),   64'(0));
        check_output("rst_done",   64'(done),   64'(0));
        check_output("rst_valid",  64'(valid),  64'(1));
        check_output("rst_ready",  64'(ready),  64'(1));
        check_output("rst_status", 64'(status), 64'(2'b11));

        apply_stimulus(1'b0, 24'd3, 24'd5, 32'h0000_000F, 6'd4, 1'b1);
        apply_stimulus(1'b0, 24'hFFFFFF, 24'hFFFFFF, 32'hFE00_0001, 6'd8, 1'b0);
        apply_stimulus(1'b1, 24'hA5A5A5, 24'h123456, 32'h00A5_A5A5, 6'd12, 1'b1);

        // start held high: back-to-back ops 58 cycles apart, operand glitch ignored
        @(negedge clk);
        k = cyc;
        mode = 1'b0; a = 24'd2; b = 24'd7; start = 1'b1;
        for (int j = 0; j < 2; j++) begin
            gpio_model = gpio_model + 1'b1;
            e.w = 32'd14; e.l = 6'd3; e.valid = 1'b1; e.gpio = gpio_model;
            e.due = k + 57 + 58*j;
            sb.push_back(e);
        end
        wait_until(k + 11);
        a = 24'd5; b = 24'd9;
        wait_until(k + 30);
        a = 24'd2; b = 24'd7;
        wait_until(k + 60);
        start = 1'b0;
        wait_drain(200);

        // reset in the middle of a multiply aborts it silently
        @(negedge clk);
        k = cyc;
        mode = 1'b0; a = 24'd9; b = 24'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_until(k + 10);
        #2 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        gpio_model = '0;
        @(negedge clk);
        check_output("abort_w",     64'(w),     64'(0));
        check_output("abort_l",     64'(l),     64'(0));
        check_output("abort_gpio",  64'(gpio),  64'(0));
        check_output("abort_valid", 64'(valid), 64'(1));
        check_output("abort_ready", 64'(ready), 64'(1));
        wait_until(k + 80);
        apply_stimulus(1'b0, 24'd1, 24'd1, 32'h0000_0001, 6'd1, 1'b1);

        // 4-bit counter wraps after 15 completed ops
        @(negedge clk);
        k = cyc;
        start4 = 1'b1;
        for (int j = 0; j < 17; j++) begin
            e4.gpio = 4'((j + 1) % 16);
            e4.due  = k + 33 + 34*j;
            sb4.push_back(e4);
        end
        wait_until(k + 546);
        start4 = 1'b0;
        wait_drain(200);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
